// File: rtl/p2s_fifo_gen.sv
// p2s_fifo_gen: parallel-to-serial converter fed by a small word FIFO.
// Words are queued in a DEPTH-entry FIFO and shifted out one bit per accepted
// beat with osop/oeop framing. The next word loads on the same edge as the
// previous word's last bit, so consecutive words stream without a gap.
// Build option: define P2S_FIFO_MSB_FIRST_EN for MSB-first bit order
// (default is LSB first). Timing and flags do not depend on the bit order.
module p2s_fifo_gen #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_h,
    input  logic                         rst_n,
    input  logic                         iflush,
    input  logic                         ival,
    input  logic [W-1:0]                 idata,
    output logic                         ireq,
    input  logic                         oready,
    output logic                         oval,
    output logic                         obit,
    output logic                         osop,
    output logic                         oeop,
    output logic [$clog2(DEPTH+1)-1:0]   olevel,
    output logic                         oovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(W);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_SHIFT = 1'b1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    // Storage is read asynchronously at the head so a pop can load the
    // shifter on the same edge that the previous word's last bit leaves.
    logic [W-1:0]  mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] level_reg,  level_next;
    logic [0:0]    state_reg,  state_next;
    logic [CW-1:0] cnt_reg,    cnt_next;
    logic [W-1:0]  word_reg,   word_next;
    logic          ovf_reg,    ovf_next;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          xfer;
    logic          last_xfer;
    logic [W-1:0]  order_word;

    // Handshake decode: what the FIFO and shifter do at the coming edge.
    always_comb begin
        full      = (level_reg == LVL_FULL);
        empty     = (level_reg == '0);
        // A full FIFO refuses writes even when a pop frees a slot this cycle.
        push      = ival & ~full & ~iflush;
        xfer      = (state_reg == ST_SHIFT) & oready;
        last_xfer = xfer & (cnt_reg == CNT_LAST);
        pop       = ~empty & ~iflush & ((state_reg == ST_IDLE) | last_xfer);
    end

    // FIFO pointer, level and sticky overflow next-state.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        ovf_next    = ovf_reg | (ival & full);
        if (iflush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
            ovf_next    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_next = level_reg + LW'(1);
                2'b01:   level_next = level_reg - LW'(1);
                default: level_next = level_reg;
            endcase
        end
    end

    // Shifter next-state: load on pop, advance on accepted beats, idle when drained.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        if (iflush) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (pop) begin
            state_next = ST_SHIFT;
            cnt_next   = '0;
            word_next  = mem[rd_ptr_reg];
        end else if (last_xfer) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (xfer) begin
            cnt_next   = cnt_reg + CW'(1);
        end
    end

    // Control and shifter registers, cleared asynchronously.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            word_reg   <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            word_reg   <= word_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Word storage; contents need no reset since the level gates every read.
    always_ff @(posedge clk_h) begin
        if (push) begin
            mem[wr_ptr_reg] <= idata;
        end
    end

    // Bit-order view of the shifter word, indexed directly by cnt.
    for (genvar gi = 0; gi < W; gi++) begin : g_order
`ifdef P2S_FIFO_MSB_FIRST_EN
        assign order_word[gi] = word_reg[W-1-gi];
`else
        assign order_word[gi] = word_reg[gi];
`endif
    end

    // Output decode; every serial flag is qualified by oval.
    always_comb begin
        oval   = (state_reg == ST_SHIFT);
        obit   = oval & order_word[cnt_reg];
        osop   = oval & (cnt_reg == '0);
        oeop   = oval & (cnt_reg == CNT_LAST);
        ireq   = ~full;
        olevel = level_reg;
        oovf   = ovf_reg;
    end

endmodule

// File: doc/p2s_fifo_gen.md
P2S_FIFO_GEN -- requirements
Module: p2s_fifo_gen

Interface
REQ-001 Parameter W, default 8: parallel word width in bits; the block SHALL support W >= 2.
REQ-002 Parameter DEPTH, default 4: FIFO depth in words; the block SHALL support powers of 2 with DEPTH >= 2.
REQ-003 clk_h  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 iflush  in  1  synchronous flush: discards FIFO contents and any word in progress.
REQ-006 ival  in  1  idata valid.
REQ-007 idata  in  W  parallel input word.
REQ-008 ireq  out  1  ready to accept a word; SHALL equal ~full.
REQ-009 oready  in  1  downstream accepts the current bit.
REQ-010 oval  out  1  obit valid.
REQ-011 obit  out  1  serial data bit; SHALL be 0 whenever oval=0.
REQ-012 osop/oeop  out  1 each  marks the first/last bit of a word; each SHALL be qualified by oval.
REQ-013 olevel  out  $clog2(DEPTH+1)  number of words in the FIFO, excluding the word in the shifter.
REQ-014 oovf  out  1  sticky overflow flag.

Function
REQ-015 Write: on an edge with ival=1 and ireq=1, idata SHALL be pushed; when full, no write SHALL occur, even if a read happens in the same cycle.
REQ-016 Overflow: on an edge with ival=1 and ireq=0, the word SHALL be dropped and oovf set; oovf SHALL clear only on reset or iflush.
REQ-017 Shifter states: IDLE and SHIFT, with bit index cnt in 0..W-1.
REQ-018 IDLE->SHIFT: when the FIFO is non-empty, the head word SHALL pop into the shifter, with cnt=0 and oval=1 after that edge.
REQ-019 A bit SHALL be transferred on an edge with oval=1 and oready=1; cnt SHALL then advance by 1.
REQ-020 When oready=0, obit, osop, oeop and cnt SHALL hold.
REQ-021 Last bit (cnt=W-1) transferred with the FIFO non-empty: the next word SHALL load on the same edge, giving zero gap between words; with the FIFO empty, the shifter SHALL return to IDLE and oval SHALL drop.
REQ-022 Latency: a word written at edge N into an empty FIFO with the shifter IDLE SHALL present its first bit (oval=1, osop=1) after edge N+1.
REQ-023 osop SHALL be 1 when cnt=0; oeop SHALL be 1 when cnt=W-1.
REQ-024 Default bit order SHALL be LSB first: obit=word[cnt].
REQ-025 Simultaneous push and pop with the FIFO not full: both SHALL complete and olevel SHALL be unchanged.
REQ-026 FIFO pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH; full/empty SHALL be derived from the level counter.
REQ-027 iflush=1: at that edge, the FIFO SHALL empty, the shifter SHALL go to IDLE with cnt=0, and oovf SHALL clear; any ival in that same cycle SHALL be ignored.

Reset
REQ-028 While rst_n=0 (asynchronously): oval=0, obit=0, osop=0, oeop=0, olevel=0, oovf=0, pointers=0, cnt=0, state=IDLE, and ireq=1.
REQ-029 Reset mid-word: the partial word SHALL be lost; after release, the first accepted word SHALL start with osop=1.

Configuration
REQ-030 Macro P2S_FIFO_MSB_FIRST_EN: when defined, obit SHALL equal word[W-1-cnt] (MSB first); when undefined, the block SHALL be LSB first per REQ-024; timing and flags SHALL be identical in both cases.

Verification
REQ-031 W=8, DEPTH=4, oready=1, push 0xA5 into an idle block -> first bit after 2 edges, LSB-first bits 1,0,1,0,0,1,0,1, osop on the 1st bit, oeop on the 8th, then oval=0.
REQ-032 Push 0x0F and 0xF0 back-to-back -> 16 consecutive oval=1 cycles, no gap, osop at bits 0 and 8.
REQ-033 oready=0, push 6 words -> ireq=0 once olevel=4 with a word in the shifter; the 6th push sets oovf=1; raise oready -> exactly 5 words are output, in order.
REQ-034 Toggle oready every cycle during 0x3C -> bit sequence 0,0,1,1,1,1,0,0 still correct, with obit held while stalled.
REQ-035 iflush or rst_n=0 at bit 3 of a word with olevel=2 -> next cycle oval=0, olevel=0, oovf=0; the next push starts with osop=1.
REQ-036 Build with P2S_FIFO_MSB_FIRST_EN, push 0xA5 -> bits 1,0,1,0,0,1,0,1 in MSB-first order, same timing as REQ-031.
